// File: rtl/uibi_xbar_if.sv
// Master-side bus of the UIBI crossbar: request fields from the master, and the
// read data / completion / error returned to it.
interface uibi_xbar_if #(
  parameter int XLEN        = 32,
  parameter int SLAVE_WIDTH = 4
);
  logic                        bus_req;
  logic                        bus_wen;
  logic [2:0]                  bus_mode;
  logic [SLAVE_WIDTH-1:0]      bus_num;
  logic [XLEN-SLAVE_WIDTH-1:0] bus_addr;
  logic [XLEN-1:0]             bus_dat_o;
  logic [XLEN-1:0]             bus_dat_i;
  logic                        bus_ready;
  logic                        bus_err;

  // master: the initiating core
  modport master (
    output bus_req, bus_wen, bus_mode, bus_num, bus_addr, bus_dat_o,
    input  bus_dat_i, bus_ready, bus_err
  );

  // slave: the crossbar's upstream port
  modport slave (
    input  bus_req, bus_wen, bus_mode, bus_num, bus_addr, bus_dat_o,
    output bus_dat_i, bus_ready, bus_err
  );
endinterface

// File: rtl/uibi_xbar.sv
// Single-master UIBI crossbar: captures one request, routes it to the addressed
// slave, waits for that slave's ready (or a timeout), then returns a one-cycle response.
module uibi_xbar #(
  parameter int                            XLEN        = 32,
  parameter int                            SLAVE_WIDTH = 4,
  parameter logic [(2**SLAVE_WIDTH)-1:0]   SLAVE_MASK  = 16'h3501,
  parameter int                            TIMEOUT     = 255
) (
  input  logic                                        clk,
  input  logic                                        rst,
  uibi_xbar_if.slave                                  mst,
  output logic [(2**SLAVE_WIDTH)-1:0]                 s_sel,
  output logic                                        s_wen,
  output logic [2:0]                                  s_mode,
  output logic [XLEN-SLAVE_WIDTH-1:0]                 s_addr,
  output logic [XLEN-1:0]                             s_dat_o,
  input  logic [(2**SLAVE_WIDTH)-1:0][XLEN-1:0]       s_dat_i,
  input  logic [(2**SLAVE_WIDTH)-1:0]                 s_ready
);
  localparam int NSLV = 2**SLAVE_WIDTH;
  localparam int AW   = XLEN - SLAVE_WIDTH;
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic                   wen;
    logic [2:0]             mode;
    logic [SLAVE_WIDTH-1:0] num;
    logic [AW-1:0]          addr;
    logic [XLEN-1:0]        dat;
  } req_t;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  req_t            req_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic mapped, hit, tmo, sel_en;

  assign mapped = SLAVE_MASK[mst.bus_num];
  assign hit    = s_ready[req_q.num];
  assign tmo    = (cnt_q == CW'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mst.bus_req) state_d = mapped ? ACCESS : RESP;
      ACCESS:  if (hit || tmo)  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    sel_en        = (state_q == ACCESS);
    mst.bus_ready = (state_q == RESP);
    mst.bus_err   = (state_q == RESP) && err_q;
    mst.bus_dat_i = rdata_q;
  end

  // request capture, access counter and response latch; ready beats timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mst.bus_req) begin
          req_q <= '{wen: mst.bus_wen, mode: mst.bus_mode, num: mst.bus_num,
                     addr: mst.bus_addr, dat: mst.bus_dat_o};
          cnt_q <= '0;
          if (!mapped) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ACCESS: begin
          if (hit) begin
            rdata_q <= s_dat_i[req_q.num];
            err_q   <= 1'b0;
          end else if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar n = 0; n < NSLV; n++) begin : g_sel
    assign s_sel[n] = sel_en && (req_q.num == SLAVE_WIDTH'(n));
  end

  assign s_wen   = req_q.wen;
  assign s_mode  = req_q.mode;
  assign s_addr  = req_q.addr;
  assign s_dat_o = req_q.dat;
endmodule

// File: tb/tb_uibi_xbar.sv
// Scoreboard bench for uibi_xbar: the driver pushes the expected response of each
// request, a negedge monitor checks slave-side broadcast and pops on bus_ready.
module tb_uibi_xbar;
  localparam int          TO   = 4;
  localparam logic [15:0] MASK = 16'h3501;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [15:0] sel;
    logic        wen;
    logic [2:0]  mode;
    logic [27:0] addr;
    logic [31:0] dat;
    int          ncyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       s_sel;
  logic              s_wen;
  logic [2:0]        s_mode;
  logic [27:0]       s_addr;
  logic [31:0]       s_dat_o;
  logic [15:0][31:0] s_dat_i;
  logic [15:0]       s_ready;
  logic [15:0][31:0] sdat;

  exp_t q[$];
  int   rdy_t[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, sel_cnt = 0, cfg_dly = 0, acc = 0;
  logic [31:0] last_rd = '0;

  uibi_xbar_if #(.XLEN(32), .SLAVE_WIDTH(4)) m();

  uibi_xbar #(.XLEN(32), .SLAVE_WIDTH(4), .SLAVE_MASK(MASK), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mst(m),
    .s_sel(s_sel), .s_wen(s_wen), .s_mode(s_mode), .s_addr(s_addr),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // slave model: selected slave answers after cfg_dly ACCESS cycles, all others always ready
  initial begin
    s_ready = '0;
    forever begin
      @(negedge clk);
      if (s_sel == '0) acc = 0;
      else             acc++;
      for (int n = 0; n < 16; n++)
        s_ready[n] = s_sel[n] ? (cfg_dly != 0 && acc == cfg_dly) : 1'b1;
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sel_cnt = 0;
        last_rd = '0;
      end else begin
        if (s_sel != '0) begin
          sel_cnt++;
          if (q.size() == 0) chk("sel_without_req", s_sel, 0);
          else begin
            chk("s_sel",   s_sel,   q[0].sel);
            chk("s_wen",   s_wen,   q[0].wen);
            chk("s_mode",  s_mode,  q[0].mode);
            chk("s_addr",  s_addr,  q[0].addr);
            chk("s_dat_o", s_dat_o, q[0].dat);
          end
        end
        if (m.bus_ready) begin
          chk("sel_in_resp", s_sel, 0);
          if (q.size() == 0) chk("unexpected_ready", 1, 0);
          else begin
            e = q.pop_front();
            chk("rdata", m.bus_dat_i, e.rdata);
            chk("err",   m.bus_err,   e.err);
            chk("access_cycles", sel_cnt, e.ncyc);
            last_rd = e.rdata;
          end
          sel_cnt = 0;
          rdy_t.push_back(cyc);
        end else begin
          chk("err_outside_resp", m.bus_err, 0);
          chk("dat_hold", m.bus_dat_i, last_rd);
        end
      end
    end
  end

  task automatic drive_rand();
    m.bus_wen   = 1'($urandom);
    m.bus_mode  = 3'($urandom);
    m.bus_num   = 4'($urandom);
    m.bus_addr  = 28'($urandom);
    m.bus_dat_o = $urandom;
  endtask

  function automatic exp_t model(input logic wen, input logic [3:0] num, input logic [2:0] md,
                                 input logic [27:0] addr, input logic [31:0] dat, input int dly);
    exp_t e;
    e.wen = wen; e.mode = md; e.addr = addr; e.dat = dat;
    if (!MASK[num]) begin
      e.sel = '0; e.rdata = '0; e.err = 1'b1; e.ncyc = 0;
    end else begin
      e.sel = 16'(1) << num;
      if (dly == 0 || dly > TO) begin
        e.rdata = '0; e.err = 1'b1; e.ncyc = TO;
      end else begin
        e.rdata = sdat[num]; e.err = 1'b0; e.ncyc = dly;
      end
    end
    return e;
  endfunction

  // call at a negedge while the DUT is idle; returns at the negedge of the following idle cycle
  task automatic issue(input logic wen, input logic [3:0] num, input logic [27:0] addr,
                       input logic [31:0] dat, input int dly, input bit hold);
    logic [2:0] md;
    bit done;
    md = 3'($urandom);
    q.push_back(model(wen, num, md, addr, dat, dly));
    cfg_dly     = dly;
    m.bus_req   = 1'b1;
    m.bus_wen   = wen;
    m.bus_mode  = md;
    m.bus_num   = num;
    m.bus_addr  = addr;
    m.bus_dat_o = dat;
    @(posedge clk); #1;
    m.bus_req = hold;
    drive_rand();
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = m.bus_ready;
    end
    if (!done) chk("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m.bus_req = 1'b0;
    drive_rand();
    for (int n = 0; n < 16; n++) sdat[n] = $urandom;
    sdat[8] = 32'h12345678;
    s_dat_i = sdat;

    repeat (2) @(posedge clk); #1;
    chk("rst_ready",  m.bus_ready, 0);
    chk("rst_err",    m.bus_err,   0);
    chk("rst_dat",    m.bus_dat_i, 0);
    chk("rst_sel",    s_sel,   0);
    chk("rst_wen",    s_wen,   0);
    chk("rst_mode",   s_mode,  0);
    chk("rst_addr",   s_addr,  0);
    chk("rst_dat_o",  s_dat_o, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 4'd8,  28'h10,        $urandom,      1, 1'b0);  // read, immediate ready
    issue(1'b1, 4'd10, 28'($urandom), 32'hA5A5A5A5,  3, 1'b0);  // write, ready on 3rd cycle
    issue(1'b0, 4'd3,  28'($urandom), $urandom,      1, 1'b0);  // unmapped
    issue(1'b0, 4'd12, 28'($urandom), $urandom,      0, 1'b0);  // timeout
    issue(1'b0, 4'd12, 28'($urandom), $urandom,      4, 1'b0);  // ready on the timeout cycle wins
    issue(1'b1, 4'd0,  28'($urandom), $urandom,      2, 1'b0);

    // back-to-back with bus_req held
    rdy_t.delete();
    for (int i = 0; i < 3; i++) begin
      sdat[0] = 32'h0B0B0000 + 32'(i);
      s_dat_i = sdat;
      issue(1'b0, 4'd0, 28'(4 * i), $urandom, 1, i < 2);
    end
    chk("b2b_pulses", rdy_t.size(), 3);
    if (rdy_t.size() == 3) begin
      chk("b2b_gap1", rdy_t[1] - rdy_t[0], 3);
      chk("b2b_gap2", rdy_t[2] - rdy_t[1], 3);
    end

    // reset during the 2nd ACCESS cycle
    q.push_back(model(1'b1, 4'd12, 3'd5, 28'h0ABCDEF, 32'hDEADBEEF, 0));
    cfg_dly     = 0;
    m.bus_req   = 1'b1;
    m.bus_wen   = 1'b1;
    m.bus_mode  = 3'd5;
    m.bus_num   = 4'd12;
    m.bus_addr  = 28'h0ABCDEF;
    m.bus_dat_o = 32'hDEADBEEF;
    @(posedge clk); #1;
    m.bus_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    void'(q.pop_front());
    chk("mid_rst_ready", m.bus_ready, 0);
    chk("mid_rst_err",   m.bus_err,   0);
    chk("mid_rst_dat",   m.bus_dat_i, 0);
    chk("mid_rst_sel",   s_sel,   0);
    chk("mid_rst_dat_o", s_dat_o, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 4'd8, 28'h20, $urandom, 2, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uibi_xbar.md
UIBI_XBAR -- requirements
Module: uibi_xbar

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter SLAVE_WIDTH, default 4, slave-number width; NSLV = 2**SLAVE_WIDTH.
REQ-003 Parameter SLAVE_MASK, default 16'h3501, bit n set = slave n present (0=IMEM, 8=DMEM, 10=DEVICE, 12=FB).
REQ-004 Parameter TIMEOUT, default 255, max ACCESS cycles before abort (1..65535).
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 bus_req  in  1  master request.
REQ-008 bus_wen  in  1  master write enable.
REQ-009 bus_mode  in  3  access size/sign mode, passed through.
REQ-010 bus_num  in  SLAVE_WIDTH  target slave number.
REQ-011 bus_addr  in  XLEN-SLAVE_WIDTH  slave-local address.
REQ-012 bus_dat_o  in  XLEN  master write data.
REQ-013 bus_dat_i  out  XLEN  read data to master.
REQ-014 bus_ready  out  1  transaction-complete pulse to master.
REQ-015 bus_err  out  1  error qualifier, valid only when bus_ready=1.
REQ-016 s_sel  out  NSLV  one-hot slave select.
REQ-017 s_wen, s_mode, s_addr, s_dat_o  out  1/3/XLEN-SLAVE_WIDTH/XLEN  registered broadcast of captured request.
REQ-018 s_dat_i  in  NSLV*XLEN  slave read data, slave n at bits [n*XLEN +: XLEN].
REQ-019 s_ready  in  NSLV  per-slave completion.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; encoding free.
REQ-021 IDLE: bus_ready=0, s_sel=0; on bus_req=1 capture wen/mode/num/addr/dat into request registers.
REQ-022 IDLE with bus_req=1 and SLAVE_MASK[bus_num]=1 -> ACCESS; counter cleared to 0.
REQ-023 IDLE with bus_req=1 and SLAVE_MASK[bus_num]=0 -> RESP with err=1, rdata=0; no s_sel asserted.
REQ-024 IDLE with bus_req=0 -> stay IDLE, request registers unchanged.
REQ-025 ACCESS: s_sel[captured num]=1 only; s_wen/s_mode/s_addr/s_dat_o = captured values, stable for whole ACCESS.
REQ-026 ACCESS with s_ready[captured num]=1 -> RESP, latch s_dat_i slice of that slave (also on writes), err=0.
REQ-027 s_ready bits of non-selected slaves ignored.
REQ-028 ACCESS without ready: counter +1 per cycle; when counter reaches TIMEOUT-1 with no ready -> RESP, err=1, rdata=0; ready in that same cycle wins over timeout.
REQ-029 RESP: exactly one cycle, bus_ready=1, bus_dat_i=latched rdata, bus_err=latched err, s_sel=0; -> IDLE unconditionally.
REQ-030 bus_dat_i holds last latched value outside RESP; bus_err=0 outside RESP.
REQ-031 Latency: mapped slave with s_ready=1 on first ACCESS cycle -> bus_ready 2 cycles after IDLE capture edge; unmapped -> 1 cycle.
REQ-032 Master inputs changing during ACCESS/RESP do not affect the transaction in flight.
REQ-033 Continuous bus_req=1 yields back-to-back transactions, one IDLE cycle between RESP and next ACCESS; new request captured from inputs of that IDLE cycle.
REQ-034 Counter width ceil(log2(TIMEOUT+1)); no wrap possible.

Reset
REQ-035 rst=1 at a clock edge -> state IDLE, counter 0, bus_ready=0, bus_err=0, bus_dat_i=0, s_sel=0, request registers 0.
REQ-036 rst mid-ACCESS or mid-RESP aborts the transaction; no bus_ready pulse issued; s_sel=0 from the cycle after the reset edge.
REQ-037 rst dominates all other inputs.

Verification
REQ-038 Read num=8, addr=28'h10, slave 8 ready on first ACCESS cycle with data 32'h12345678 -> bus_ready=1 one cycle, bus_dat_i=32'h12345678, bus_err=0, 2 cycles after capture.
REQ-039 Write num=10, dat=32'hA5A5A5A5, slave 10 ready after 3 cycles -> s_sel=16'h0400 for 3 cycles, s_dat_o=32'hA5A5A5A5 stable, bus_ready pulse, bus_err=0.
REQ-040 Request num=3 (unmapped) -> s_sel stays 0, RESP next cycle, bus_err=1, bus_dat_i=0.
REQ-041 TIMEOUT=4, num=12, s_ready never asserted -> s_sel=16'h1000 for 4 cycles, then bus_ready=1, bus_err=1, bus_dat_i=0.
REQ-042 rst asserted during 2nd ACCESS cycle -> no bus_ready pulse, all outputs at reset values, next request completes normally.
REQ-043 bus_req held 1, addresses 0x0/0x4/0x8 on num=0, ready immediate -> three bus_ready pulses 3 cycles apart, data in order.
